// File: rtl/snake_dir_ctrl_if.sv
// Button/VGA-line inputs and direction outputs of snake_dir_ctrl.
// master: the side that drives buttons, y_pos and game_state.
// slave: the direction controller itself.
interface snake_dir_ctrl_if #(
  parameter int unsigned BIT = 10
) ();
  logic [BIT-1:0] y_pos;
  logic [1:0]     game_state;
  logic           btn_up;
  logic           btn_down;
  logic           btn_left;
  logic           btn_right;
  logic [2:0]     direction;
  logic           dir_changed;
  logic           req_rejected;

  modport master (
    output y_pos, game_state, btn_up, btn_down, btn_left, btn_right,
    input  direction, dir_changed, req_rejected
  );

  modport slave (
    input  y_pos, game_state, btn_up, btn_down, btn_left, btn_right,
    output direction, dir_changed, req_rejected
  );
endinterface

// File: rtl/snake_dir_ctrl.sv
// Snake direction controller: synchronises and debounces four push-buttons,
// edge-detects presses, buffers the newest request and commits it once per
// frame at y_pos == UPDATE_LINE. Reversals are rejected; outside PLAY the
// direction is forced to IDLE.
// Optional: define SNAKE_DIR_QUEUE_EN to turn the pending register into a
// 2-entry FIFO that commits one entry per frame.
module snake_dir_ctrl #(
  parameter int unsigned BIT             = 10,
  parameter int unsigned UPDATE_LINE     = 480,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 18
) (
  input logic             clk,
  input logic             reset,
  snake_dir_ctrl_if.slave bus
);

  localparam logic [2:0] DirIdle  = 3'd0;
  localparam logic [2:0] DirUp    = 3'd1;
  localparam logic [2:0] DirDown  = 3'd2;
  localparam logic [2:0] DirLeft  = 3'd3;
  localparam logic [2:0] DirRight = 3'd4;
  localparam logic [1:0] StPlay   = 2'b01;

  localparam logic [CNT_W-1:0] DebLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  function automatic logic [2:0] opposite(input logic [2:0] d);
    logic [2:0] o;
    case (d)
      DirUp:    o = DirDown;
      DirDown:  o = DirUp;
      DirLeft:  o = DirRight;
      DirRight: o = DirLeft;
      default:  o = DirIdle;
    endcase
    return o;
  endfunction

  // Button vector, bit 0 = up, 1 = down, 2 = left, 3 = right.
  logic [3:0]       raw;
  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       lvl_q, lvl_d, lvl_prev_q;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       press;
  logic             press_any;
  logic [2:0]       press_dir;

  logic             cmp, cmp_q, tick, play;
  logic             cand_valid;
  logic [2:0]       cand_dir;
  logic [2:0]       dir_q, dir_d;
  logic             chg_q, chg_d, rej_q, rej_d;

  assign raw  = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
  assign play = (bus.game_state == StPlay);
  assign cmp  = (bus.y_pos == BIT'(UPDATE_LINE));
  assign tick = cmp & ~cmp_q;

  // Synchroniser, debounce and line-compare state.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      cnt_q      <= '{default: '0};
      cmp_q      <= 1'b0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_q;
      cnt_q      <= cnt_d;
      cmp_q      <= cmp;
    end
  end

  // Debounce: count consecutive disagreeing samples, flip level on the last one.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lvl_d[i] = lvl_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == DebLast) begin
          lvl_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign press     = lvl_q & ~lvl_prev_q;
  assign press_any = |press;

  // Simultaneous presses resolve UP > DOWN > LEFT > RIGHT.
  always_comb begin
    press_dir = DirIdle;
    if (press[0])      press_dir = DirUp;
    else if (press[1]) press_dir = DirDown;
    else if (press[2]) press_dir = DirLeft;
    else if (press[3]) press_dir = DirRight;
  end

`ifdef SNAKE_DIR_QUEUE_EN
  logic [2:0] q_dir_q [2];
  logic [2:0] q_dir_d [2];
  logic [1:0] q_cnt_q, q_cnt_d;
  logic [2:0] q_last;

  // Request FIFO state.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_dir_q <= '{default: DirIdle};
      q_cnt_q <= 2'd0;
    end else begin
      q_dir_q <= q_dir_d;
      q_cnt_q <= q_cnt_d;
    end
  end

  // Push a press that differs from the newest entry, then pop one at tick.
  always_comb begin
    q_dir_d = q_dir_q;
    q_cnt_d = q_cnt_q;
    q_last  = dir_q;
    if (q_cnt_q == 2'd1)      q_last = q_dir_q[0];
    else if (q_cnt_q == 2'd2) q_last = q_dir_q[1];
    if (press_any && (press_dir != q_last)) begin
      if (q_cnt_q == 2'd2) begin
        q_dir_d[1] = press_dir;
      end else begin
        q_dir_d[q_cnt_q[0]] = press_dir;
        q_cnt_d             = q_cnt_q + 2'd1;
      end
    end
    cand_valid = tick && (q_cnt_d != 2'd0);
    cand_dir   = q_dir_d[0];
    if (cand_valid) begin
      q_dir_d[0] = q_dir_d[1];
      q_cnt_d    = q_cnt_d - 2'd1;
    end
    if (!play) q_cnt_d = 2'd0;
  end
`else
  logic       pend_valid_q, pend_valid_d;
  logic [2:0] pend_dir_q, pend_dir_d;

  // Single pending request.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
      pend_dir_q   <= DirIdle;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_dir_q   <= pend_dir_d;
    end
  end

  // A same-clock press overwrites pending before the tick consumes it.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_dir_d   = pend_dir_q;
    if (press_any) begin
      pend_valid_d = 1'b1;
      pend_dir_d   = press_dir;
    end
    cand_valid = tick && pend_valid_d;
    cand_dir   = pend_dir_d;
    if (tick || !play) pend_valid_d = 1'b0;
  end
`endif

  // Commit rules: equal drops silently, reversal drops with a pulse.
  always_comb begin
    dir_d = dir_q;
    chg_d = 1'b0;
    rej_d = 1'b0;
    if (!play) begin
      dir_d = DirIdle;
      chg_d = (dir_q != DirIdle);
    end else if (cand_valid && (cand_dir != dir_q)) begin
      if ((dir_q != DirIdle) && (cand_dir == opposite(dir_q))) begin
        rej_d = 1'b1;
      end else begin
        dir_d = cand_dir;
        chg_d = 1'b1;
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q <= DirIdle;
      chg_q <= 1'b0;
      rej_q <= 1'b0;
    end else begin
      dir_q <= dir_d;
      chg_q <= chg_d;
      rej_q <= rej_d;
    end
  end

  assign bus.direction    = dir_q;
  assign bus.dir_changed  = chg_q;
  assign bus.req_rejected = rej_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl with DEBOUNCE_CYCLES = 16: a frame-level model
// checked every cycle, plus directed literal expectations.
module tb_snake_dir_ctrl;
  localparam int unsigned Deb = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;

  snake_dir_ctrl_if #(.BIT(10)) bus ();

  snake_dir_ctrl #(
    .BIT(10),
    .UPDATE_LINE(480),
    .DEBOUNCE_CYCLES(16),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model state.
  logic           m_ok = 1'b0;
  logic [2:0]     m_dir;
  logic           m_chg, m_rej;
  logic [3:0]     m_s1, m_s2, m_lvl, m_rise;
  logic [Deb-1:0] m_win [4];
  logic           m_prev_line;
`ifdef SNAKE_DIR_QUEUE_EN
  logic [2:0]     m_q [$];
`else
  logic           m_pv;
  logic [2:0]     m_pd;
`endif

  function automatic logic is_reverse(input logic [2:0] a, input logic [2:0] b);
    // UP/DOWN share axis 1, LEFT/RIGHT share axis 2.
    return (a != 0) && (b != 0) && (a != b) && (((a + 1) / 2) == ((b + 1) / 2));
  endfunction

  task automatic apply(input logic [2:0] p);
    if (p == m_dir) return;
    if (is_reverse(p, m_dir)) m_rej = 1'b1;
    else begin
      m_dir = p;
      m_chg = 1'b1;
    end
  endtask

  // Reference model, advanced on every clock edge.
  always @(posedge clk) begin : model
    logic [3:0] raw;
    logic       tk;
    logic [2:0] pd;
    raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
    if (reset) begin
      m_ok = 1'b1; m_dir = 0; m_chg = 0; m_rej = 0;
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_rise = 0; m_prev_line = 0;
      for (int b = 0; b < 4; b++) m_win[b] = '0;
`ifdef SNAKE_DIR_QUEUE_EN
      m_q.delete();
`else
      m_pv = 0; m_pd = 0;
`endif
    end else begin
      tk = (bus.y_pos == 10'd480) && !m_prev_line;
      m_prev_line = (bus.y_pos == 10'd480);
      m_chg = 0;
      m_rej = 0;
      pd = 0;
      for (int b = 3; b >= 0; b--) if (m_rise[b]) pd = 3'(b + 1);
      if (bus.game_state != 2'b01) begin
        if (m_dir != 0) m_chg = 1'b1;
        m_dir = 0;
`ifdef SNAKE_DIR_QUEUE_EN
        m_q.delete();
`else
        m_pv = 0;
`endif
      end else begin
`ifdef SNAKE_DIR_QUEUE_EN
        if (pd != 0 && pd != ((m_q.size() > 0) ? m_q[$] : m_dir)) begin
          if (m_q.size() == 2) m_q[1] = pd;
          else m_q.push_back(pd);
        end
        if (tk && m_q.size() > 0) apply(m_q.pop_front());
`else
        if (pd != 0) begin
          m_pv = 1'b1;
          m_pd = pd;
        end
        if (tk && m_pv) begin
          apply(m_pd);
          m_pv = 1'b0;
        end
`endif
      end
      // Level flips once the last Deb synchronised samples all disagree with it.
      for (int b = 0; b < 4; b++) begin
        m_rise[b] = 1'b0;
        m_win[b]  = {m_win[b][Deb-2:0], m_s2[b]};
        if (m_win[b] == {Deb{~m_lvl[b]}}) begin
          m_lvl[b]  = ~m_lvl[b];
          m_rise[b] = m_lvl[b];
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_ok) begin
      check("model direction", 32'(bus.direction), 32'(m_dir));
      check("model dir_changed", 32'(bus.dir_changed), 32'(m_chg));
      check("model req_rejected", 32'(bus.req_rejected), 32'(m_rej));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic [3:0] m);
    {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up} = m;
  endtask

  task automatic press(input logic [3:0] m);
    set_btn(m);
    step(30);
    set_btn(4'b0000);
    step(30);
  endtask

  // Leaves the line, then returns: after this the tick edge has just passed.
  task automatic tick_line();
    bus.y_pos = 10'd0;
    step(2);
    bus.y_pos = 10'd480;
    step(1);
  endtask

  initial begin
    bus.y_pos = 10'd0;
    bus.game_state = 2'b00;
    set_btn(4'b0000);
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    bus.game_state = 2'b01;
    step(5);
    check("reset direction", 32'(bus.direction), 32'd0);
    check("reset dir_changed", 32'(bus.dir_changed), 32'd0);
    check("reset req_rejected", 32'(bus.req_rejected), 32'd0);

    // RIGHT held 30 clocks; no commit until the tick.
    set_btn(4'b1000);
    step(30);
    check("right pre-tick", 32'(bus.direction), 32'd0);
    set_btn(4'b0000);
    step(30);
    tick_line();
    check("right committed", 32'(bus.direction), 32'd4);
    check("right dir_changed", 32'(bus.dir_changed), 32'd1);
    step(1);
    check("right pulse ends", 32'(bus.dir_changed), 32'd0);

    // LEFT while moving RIGHT is a reversal.
    press(4'b0100);
    tick_line();
    check("reverse keeps dir", 32'(bus.direction), 32'd4);
    check("reverse rejected", 32'(bus.req_rejected), 32'd1);
    step(1);
    check("reject pulse ends", 32'(bus.req_rejected), 32'd0);
    tick_line();
    check("cleared no reject", 32'(bus.req_rejected), 32'd0);
    check("cleared no change", 32'(bus.dir_changed), 32'd0);

    // 10-clock glitch never debounces.
    set_btn(4'b0001);
    step(10);
    set_btn(4'b0000);
    step(30);
    for (int i = 0; i < 3; i++) begin
      tick_line();
      check("glitch ignored", 32'(bus.direction), 32'd4);
    end

    // Back to IDLE, then UP+LEFT together: UP wins.
    bus.game_state = 2'b00;
    step(1);
    check("wait forces idle", 32'(bus.direction), 32'd0);
    check("wait idle pulse", 32'(bus.dir_changed), 32'd1);
    step(2);
    bus.game_state = 2'b01;
    press(4'b0101);
    tick_line();
    check("up priority", 32'(bus.direction), 32'd1);
    check("up dir_changed", 32'(bus.dir_changed), 32'd1);
    step(2);
    bus.game_state = 2'b11;
    step(1);
    check("game over idle", 32'(bus.direction), 32'd0);
    check("game over pulse", 32'(bus.dir_changed), 32'd1);
    bus.game_state = 2'b01;
    step(2);

    // RIGHT, then UP and LEFT within one frame.
    press(4'b1000);
    tick_line();
    check("right again", 32'(bus.direction), 32'd4);
    press(4'b0001);
    press(4'b0100);
    tick_line();
`ifdef SNAKE_DIR_QUEUE_EN
    check("queue tick1 dir", 32'(bus.direction), 32'd1);
    check("queue tick1 rej", 32'(bus.req_rejected), 32'd0);
    tick_line();
    check("queue tick2 dir", 32'(bus.direction), 32'd3);
    check("queue tick2 rej", 32'(bus.req_rejected), 32'd0);
`else
    check("newest wins dir", 32'(bus.direction), 32'd4);
    check("newest wins rej", 32'(bus.req_rejected), 32'd1);
    tick_line();
    check("nothing pending", 32'(bus.direction), 32'd4);
    check("nothing pending rej", 32'(bus.req_rejected), 32'd0);
`endif

    // Reset mid-debounce with DOWN held.
    set_btn(4'b0010);
    step(8);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
    check("post-reset dir", 32'(bus.direction), 32'd0);
    check("post-reset chg", 32'(bus.dir_changed), 32'd0);
    check("post-reset rej", 32'(bus.req_rejected), 32'd0);
    step(30);
    set_btn(4'b0000);
    step(30);
    tick_line();
    check("down after reset", 32'(bus.direction), 32'd2);
    step(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/snake_dir_ctrl.md
Name: snake_dir_ctrl

Overview:
- Upstream of the snake drawing stage: converts four raw push-buttons into the 3-bit `direction` that the drawing stage consumes.
- Synchronises and debounces each button, then edge-detects presses.
- Buffers the latest press and commits it only once per frame, during vertical blanking, so the head never changes direction mid-frame.
- Rejects 180-degree reversals and forces IDLE outside the PLAY state.

Parameters:
- BIT, 10: width of y_pos.
- UPDATE_LINE, 480: y_pos value whose first clock produces the frame tick. Must be below the drawing stage's move line (490).
- DEBOUNCE_CYCLES, 250000: consecutive stable synchronised samples needed before a debounced level changes (10 ms at 25 MHz).
- CNT_W, 18: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high.
- y_pos  in  BIT  current VGA line counter.
- game_state  in  2  00 WAIT, 01 PLAY, 11 GAME_OVER, 10 reserved (treated as WAIT).
- btn_up, btn_down, btn_left, btn_right  in  1 each  raw asynchronous buttons, active-high.
- direction  out  3  000 IDLE, 001 UP, 010 DOWN, 011 LEFT, 100 RIGHT.
- dir_changed  out  1  one-cycle pulse on the clock where `direction` takes a new value.
- req_rejected  out  1  one-cycle pulse when a pending request is discarded at a frame tick.

Behaviour:
- Reset: direction=IDLE; dir_changed=0; req_rejected=0; all sync flops, debounced levels, counters, pending registers cleared.
- Synchroniser:
  - Two flops per button.
  - Raw-to-synchronised latency is 2 clocks.
- Debounce, per button:
  - Counter resets to 0 whenever synchronised value == debounced level.
  - Otherwise the counter increments.
  - On the clock the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the synchronised value and the counter resets to 0.
  - Glitches shorter than DEBOUNCE_CYCLES never change the level.
- Press event: rising edge of the debounced level; 1-cycle pulse, one clock after the level changes.
- Pending register (valid + 3-bit dir):
  - Loaded on any press event while game_state==PLAY; the newest press overwrites any older pending request.
  - Simultaneous presses on one clock: priority UP > DOWN > LEFT > RIGHT.
- Frame tick:
  - tick = (y_pos==UPDATE_LINE) && !(registered previous-cycle comparison).
  - Exactly one pulse per frame, on the first clock of that line.
- At tick with game_state==PLAY and pending valid:
  - If pending equals the current direction: drop silently; no pulses.
  - Else if pending is the exact opposite of a non-IDLE current direction: drop; req_rejected=1 for 1 cycle.
  - Else: direction <= pending on the clock after the tick; dir_changed=1 on that same clock.
  - In all cases pending is cleared.
- Press event and tick on the same clock: the press is used (it overwrites pending first), then the commit rules above apply.
- game_state != PLAY:
  - direction is forced to IDLE on the next clock; dir_changed pulses if the previous value was not IDLE.
  - Pending is cleared; presses are ignored.
- Reset mid-debounce or mid-frame: all state returns to reset values; no pulses on the clock after reset deasserts.

Optional Feature:
- Macro: SNAKE_DIR_QUEUE_EN.
- Defined:
  - Pending becomes a 2-entry FIFO.
  - A press is pushed only if it differs from the last queued entry (or from the current direction when the FIFO is empty).
  - If the FIFO is full, the newest entry is overwritten.
  - Each tick pops one entry and applies the commit rules; a second entry waits for the next frame.
  - Reversal is checked against the direction in effect at the time of the pop.
  - Non-PLAY flushes the FIFO.
- Undefined: single pending register exactly as described in Behaviour.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=16.
- Reset, then game_state=PLAY -> direction=000, dir_changed and req_rejected stay 0.
- btn_right held 30 clocks, then y_pos stepped to 480 -> direction=100 one clock after the tick, dir_changed single pulse, no change before the tick.
- direction=100, btn_left pressed, tick -> direction stays 100, req_rejected pulses once, pending cleared (a second tick gives no pulse).
- 10-clock glitch on btn_up -> no press event, direction unchanged across 3 ticks.
- btn_up and btn_left rising on the same clock, direction=IDLE, tick -> direction=001. Then game_state=11 -> direction=000 next clock, dir_changed=1.
- SNAKE_DIR_QUEUE_EN defined, direction=100, press UP then LEFT within one frame -> tick1: 001; tick2: 011; no req_rejected.
